// File: rtl/divider_operand_feeder_if.sv
// Operand bus between the producers, the operand feeder and the 8-bit divider.
// The master side drives the producer words and the divider acknowledges.
interface divider_operand_feeder_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  a_data;
  logic          a_valid;
  logic          a_ready;
  logic [W-1:0]  b_data;
  logic          b_valid;
  logic          b_ready;
  logic [W-1:0]  dividend_data;
  logic          dividend_valid;
  logic          dividend_ready;
  logic [W-1:0]  divisor_data;
  logic          divisor_valid;
  logic          divisor_ready;
  logic [LW-1:0] level;
  logic [15:0]   pairs_sent;
  logic          dz_seen;

  modport master (
    output a_data, a_valid, b_data, b_valid, dividend_ready, divisor_ready,
    input  a_ready, b_ready, dividend_data, dividend_valid,
           divisor_data, divisor_valid, level, pairs_sent, dz_seen
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, dividend_ready, divisor_ready,
    output a_ready, b_ready, dividend_data, dividend_valid,
           divisor_data, divisor_valid, level, pairs_sent, dz_seen
  );
endinterface

// File: rtl/divider_operand_feeder.sv
// Dual operand FIFO that pairs dividend and divisor heads for the divider and
// retires a pair only on the divider's post-capture acknowledge pulse.
module divider_operand_feeder #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  divider_operand_feeder_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];
  logic [PW-1:0] wr_a_q, wr_a_d, rd_a_q, rd_a_d;
  logic [PW-1:0] wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [15:0]   sent_q, sent_d;
  logic          dz_q, dz_d;

  logic          a_ready, b_ready, pair_valid;
  logic          push_a, push_b, ack;
  logic [W-1:0]  head_a, head_b;

  // Readiness and validity come only from registered counts, so the divider's
  // acknowledge never reaches a ready or valid combinationally.
  assign a_ready    = (cnt_a_q != CNT_FULL) && !arst;
  assign b_ready    = (cnt_b_q != CNT_FULL) && !arst;
  assign pair_valid = (cnt_a_q != '0) && (cnt_b_q != '0) && !arst;

  assign push_a = bus.a_valid && a_ready;
  assign push_b = bus.b_valid && b_ready;
  assign ack    = bus.dividend_ready && bus.divisor_ready && pair_valid;

  assign head_a = mem_a_q[rd_a_q];
  assign head_b = mem_b_q[rd_b_q];

  always_comb begin
    wr_a_d  = wr_a_q;
    rd_a_d  = rd_a_q;
    cnt_a_d = cnt_a_q;
    wr_b_d  = wr_b_q;
    rd_b_d  = rd_b_q;
    cnt_b_d = cnt_b_q;
    sent_d  = sent_q;
    dz_d    = dz_q;

    if (push_a) wr_a_d = wr_a_q + PW'(1);
    if (push_b) wr_b_d = wr_b_q + PW'(1);
    if (ack) begin
      rd_a_d = rd_a_q + PW'(1);
      rd_b_d = rd_b_q + PW'(1);
      sent_d = sent_q + 16'd1;
      if (head_b == '0) dz_d = 1'b1;
    end

    // A simultaneous push and pop leaves the count unchanged.
    if (push_a && !ack)      cnt_a_d = cnt_a_q + CW'(1);
    else if (!push_a && ack) cnt_a_d = cnt_a_q - CW'(1);
    if (push_b && !ack)      cnt_b_d = cnt_b_q + CW'(1);
    else if (!push_b && ack) cnt_b_d = cnt_b_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wr_a_q  <= '0;
      rd_a_q  <= '0;
      cnt_a_q <= '0;
      wr_b_q  <= '0;
      rd_b_q  <= '0;
      cnt_b_q <= '0;
      sent_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      wr_a_q  <= wr_a_d;
      rd_a_q  <= rd_a_d;
      cnt_a_q <= cnt_a_d;
      wr_b_q  <= wr_b_d;
      rd_b_q  <= rd_b_d;
      cnt_b_q <= cnt_b_d;
      sent_q  <= sent_d;
      dz_q    <= dz_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once counts clear.
  always_ff @(posedge clk) begin
    if (push_a) mem_a_q[wr_a_q] <= bus.a_data;
    if (push_b) mem_b_q[wr_b_q] <= bus.b_data;
  end

  assign bus.a_ready        = a_ready;
  assign bus.b_ready        = b_ready;
  assign bus.dividend_data  = head_a;
  assign bus.divisor_data   = head_b;
  assign bus.dividend_valid = pair_valid;
  assign bus.divisor_valid  = pair_valid;
  assign bus.level          = (cnt_a_q < cnt_b_q) ? cnt_a_q : cnt_b_q;
  assign bus.pairs_sent     = sent_q;
  assign bus.dz_seen        = dz_q;
endmodule

// File: tb/tb_divider_operand_feeder.sv
// Directed and randomized bench for divider_operand_feeder, compared against a
// queue-based reference model of the two operand FIFOs.
module tb_divider_operand_feeder;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic arst;

  divider_operand_feeder_if #(.W(W), .DEPTH(DEPTH)) bus ();

  divider_operand_feeder #(.W(W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [15:0]  m_sent;
  logic         m_dz;
  logic [W-1:0] cap_a[$];
  logic [W-1:0] cap_b[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_valid();
    return (qa.size() != 0) && (qb.size() != 0) && !arst;
  endfunction

  task automatic check_all();
    logic v;
    int   lv;
    v  = m_valid();
    lv = (qa.size() < qb.size()) ? qa.size() : qb.size();
    chk("a_ready", 32'(bus.a_ready), 32'((qa.size() != DEPTH) && !arst));
    chk("b_ready", 32'(bus.b_ready), 32'((qb.size() != DEPTH) && !arst));
    chk("dividend_valid", 32'(bus.dividend_valid), 32'(v));
    chk("divisor_valid", 32'(bus.divisor_valid), 32'(v));
    chk("level", 32'(bus.level), 32'(lv));
    chk("pairs_sent", 32'(bus.pairs_sent), 32'(m_sent));
    chk("dz_seen", 32'(bus.dz_seen), 32'(m_dz));
    if (v) begin
      chk("dividend_data", 32'(bus.dividend_data), 32'(qa[0]));
      chk("divisor_data", 32'(bus.divisor_data), 32'(qb[0]));
    end
  endtask

  // One clock: decide what the edge does from the pre-edge state, then apply it.
  task automatic tick();
    logic pa, pb, ack;
    logic [W-1:0] da, db;
    pa  = bus.a_valid && (qa.size() != DEPTH) && !arst;
    pb  = bus.b_valid && (qb.size() != DEPTH) && !arst;
    ack = bus.dividend_ready && bus.divisor_ready && m_valid();
    da  = bus.a_data;
    db  = bus.b_data;
    if (ack) begin
      cap_a.push_back(bus.dividend_data);
      cap_b.push_back(bus.divisor_data);
    end
    @(posedge clk);
    #1;
    if (arst) begin
      qa.delete();
      qb.delete();
      m_sent = '0;
      m_dz   = 1'b0;
    end else begin
      if (ack) begin
        if (qb[0] == '0) m_dz = 1'b1;
        void'(qa.pop_front());
        void'(qb.pop_front());
        m_sent++;
      end
      if (pa) qa.push_back(da);
      if (pb) qb.push_back(db);
    end
    check_all();
  endtask

  task automatic do_reset(input int n);
    arst               = 1'b1;
    bus.a_valid        = 1'b0;
    bus.b_valid        = 1'b0;
    bus.dividend_ready = 1'b0;
    bus.divisor_ready  = 1'b0;
    repeat (n) tick();
    arst = 1'b0;
    #1;
    check_all();
  endtask

  task automatic ack_pulse();
    bus.dividend_ready = 1'b1;
    bus.divisor_ready  = 1'b1;
    tick();
    bus.dividend_ready = 1'b0;
    bus.divisor_ready  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a2[3];
    logic [W-1:0] b2[3];
    logic [W-1:0] sa[20];
    logic [W-1:0] sb[20];
    int ia, ib, cyc, w;
    logic pa, pb;

    arst = 1'b1;
    bus.a_data = '0; bus.b_data = '0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.dividend_ready = 1'b0; bus.divisor_ready = 1'b0;
    m_sent = '0; m_dz = 1'b0;

    // Pairing: dividend waits for its divisor.
    do_reset(2);
    chk("rst_level", 32'(bus.level), 32'(0));
    chk("rst_pairs_sent", 32'(bus.pairs_sent), 32'(0));
    bus.a_data = 8'd100; bus.a_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0;
    repeat (3) tick();
    chk("pair_wait_valid", 32'(bus.dividend_valid), 32'(0));
    bus.b_data = 8'd7; bus.b_valid = 1'b1;
    tick();
    bus.b_valid = 1'b0;
    chk("pair_valid", 32'(bus.dividend_valid), 32'(1));
    chk("pair_a", 32'(bus.dividend_data), 32'(100));
    chk("pair_b", 32'(bus.divisor_data), 32'(7));
    chk("pair_level", 32'(bus.level), 32'(1));

    // Acknowledge pulse with a modelled busy divider.
    do_reset(1);
    a2[0] = 8'd200; a2[1] = 8'd50; a2[2] = 8'd8;
    b2[0] = 8'd9;   b2[1] = 8'd5;  b2[2] = 8'd0;
    cap_a.delete(); cap_b.delete();
    for (int k = 0; k < 3; k++) begin
      bus.a_data = a2[k]; bus.b_data = b2[k];
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (!bus.dividend_valid && w < 20) begin
        tick();
        w++;
      end
      chk("div_wait_valid", 32'(w < 20), 32'(1));
      tick();
      bus.dividend_ready = 1'b1; bus.divisor_ready = 1'b1;
      chk("dz_before_ack", 32'(bus.dz_seen), 32'(0));
      tick();
      bus.dividend_ready = 1'b0; bus.divisor_ready = 1'b0;
      chk("dz_after_ack", 32'(bus.dz_seen), 32'(k == 2));
      repeat (10) tick();
    end
    chk("div_count", 32'(cap_a.size()), 32'(3));
    for (int k = 0; k < 3 && k < cap_a.size(); k++) begin
      chk("div_order_a", 32'(cap_a[k]), 32'(a2[k]));
      chk("div_order_b", 32'(cap_b[k]), 32'(b2[k]));
    end
    chk("div_pairs_sent", 32'(bus.pairs_sent), 32'(3));
    chk("div_valid_low", 32'(bus.dividend_valid), 32'(0));

    // Full: the fifth dividend is held off until the first acknowledge.
    do_reset(1);
    bus.a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a_data = 8'(i + 1);
      tick();
    end
    bus.a_data = 8'd5;
    tick();
    chk("full_a_ready", 32'(bus.a_ready), 32'(0));
    chk("full_valid", 32'(bus.dividend_valid), 32'(0));
    chk("full_level", 32'(bus.level), 32'(0));
    bus.b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.b_data = 8'(10 + i);
      tick();
    end
    bus.b_valid = 1'b0;
    chk("full_level4", 32'(bus.level), 32'(4));
    chk("full_a_ready_held", 32'(bus.a_ready), 32'(0));
    ack_pulse();
    chk("full_a_ready_rise", 32'(bus.a_ready), 32'(1));
    chk("full_next_a", 32'(bus.dividend_data), 32'(2));
    tick();
    bus.a_valid = 1'b0;
    chk("full_level3", 32'(bus.level), 32'(3));

    // Lone acknowledges are ignored.
    bus.dividend_ready = 1'b1;
    tick();
    bus.dividend_ready = 1'b0;
    bus.divisor_ready = 1'b1;
    tick();
    bus.divisor_ready = 1'b0;
    chk("lone_pairs_sent", 32'(bus.pairs_sent), 32'(1));
    chk("lone_level", 32'(bus.level), 32'(3));
    ack_pulse();
    chk("both_pairs_sent", 32'(bus.pairs_sent), 32'(2));
    chk("both_level", 32'(bus.level), 32'(2));
    chk("both_head_b", 32'(bus.divisor_data), 32'(12));

    // Reset mid-stream drops queued pairs.
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      bus.a_data = 8'(20 + i); bus.b_data = 8'(1 + i);
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    ack_pulse();
    tick();
    ack_pulse();
    for (int i = 0; i < 3; i++) begin
      bus.a_data = 8'(30 + i); bus.b_data = 8'(3 + i);
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("mid_level", 32'(bus.level), 32'(3));
    chk("mid_pairs_sent", 32'(bus.pairs_sent), 32'(2));
    arst = 1'b1;
    #1;
    chk("mid_rst_a_ready", 32'(bus.a_ready), 32'(0));
    chk("mid_rst_valid", 32'(bus.divisor_valid), 32'(0));
    tick();
    chk("mid_rst_level", 32'(bus.level), 32'(0));
    chk("mid_rst_pairs_sent", 32'(bus.pairs_sent), 32'(0));
    arst = 1'b0;
    #1;
    chk("mid_ready_back", 32'(bus.b_ready), 32'(1));
    chk("mid_valid_low", 32'(bus.dividend_valid), 32'(0));
    bus.a_data = 8'd9; bus.b_data = 8'd3;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("mid_new_valid", 32'(bus.dividend_valid), 32'(1));
    chk("mid_new_a", 32'(bus.dividend_data), 32'(9));
    chk("mid_new_b", 32'(bus.divisor_data), 32'(3));

    // Wrap: 20 random pairs, acknowledged whenever a pair is presented.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    cap_a.delete(); cap_b.delete();
    ia = 0; ib = 0; cyc = 0;
    while (cap_a.size() < 20 && cyc < 400) begin
      bus.a_valid = (ia < 20) && ($urandom_range(0, 3) != 0);
      bus.b_valid = (ib < 20) && ($urandom_range(0, 3) != 0);
      bus.a_data  = (ia < 20) ? sa[ia] : '0;
      bus.b_data  = (ib < 20) ? sb[ib] : '0;
      bus.dividend_ready = m_valid();
      bus.divisor_ready  = m_valid();
      pa = bus.a_valid && (qa.size() != DEPTH);
      pb = bus.b_valid && (qb.size() != DEPTH);
      tick();
      if (pa) ia++;
      if (pb) ib++;
      cyc++;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.dividend_ready = 1'b0; bus.divisor_ready = 1'b0;
    chk("wrap_count", 32'(cap_a.size()), 32'(20));
    for (int i = 0; i < 20 && i < cap_a.size(); i++) begin
      chk("wrap_a", 32'(cap_a[i]), 32'(sa[i]));
      chk("wrap_b", 32'(cap_b[i]), 32'(sb[i]));
    end
    chk("wrap_pairs_sent", 32'(bus.pairs_sent), 32'(20));
    tick();
    chk("wrap_valid_low", 32'(bus.dividend_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
